dnn_fc_sigmoid_gen: RTL

DNN_FC_SIGMOID_GEN -- requirements
Module: dnn_fc_sigmoid_gen

---
 rtl/dnn_fc_sigmoid_gen.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dnn_fc_sigmoid_gen.sv
// Fully-connected layer with sigmoid LUT and argmax, sequenced over a single shared read port.
// Activations are buffered once, then each neuron runs MAC -> LUT lookup before a final argmax scan.
module dnn_fc_sigmoid_gen #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 16,
  parameter int N_IN          = 784,
  parameter int N_OUT         = 10,
  parameter int ADDR_BASE_A   = 0,
  parameter int ADDR_BASE_W   = 0,
  parameter int ADDR_BASE_LUT = 0,
  parameter int LUT_AW        = 15,
  parameter int LUT_SHIFT     = 0,
  parameter int ONE_VAL       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         reset,
  output logic                         done,
  output logic                         busy,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic signed [DATA_WIDTH-1:0] mem_data,
  output logic signed [DATA_WIDTH-1:0] out [N_OUT],
  output logic [$clog2(N_OUT)-1:0]     class_idx,
  output logic signed [DATA_WIDTH-1:0] class_val
);

  localparam int ACC_W  = 2*DATA_WIDTH + $clog2(N_IN+2);
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam int CNT_W  = $clog2(N_IN + N_OUT + 2);
  localparam int CI_W   = $clog2(N_OUT);
  localparam int AK_W   = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic signed [DATA_WIDTH-1:0] ONE_S  = DATA_WIDTH'(ONE_VAL);
  localparam logic signed [ACC_W-1:0]      SAT_HI = ACC_W'((2**(LUT_AW-1)) - 1);
  localparam logic signed [ACC_W-1:0]      SAT_LO = ~SAT_HI;
  localparam logic [LUT_AW-1:0]            IDX_OFS = LUT_AW'(2**(LUT_AW-1));
  localparam logic [ADDR_WIDTH-1:0]        ROW_STRIDE = ADDR_WIDTH'(N_IN+1);
  localparam logic [CNT_W-1:0]             LOAD_LAST = CNT_W'(N_IN-1);
  localparam logic [CNT_W-1:0]             MAC_LAST  = CNT_W'(N_IN);
  localparam logic [CNT_W-1:0]             ARG_LAST  = CNT_W'(N_OUT-1);
  localparam logic [CI_W-1:0]              NEUR_LAST = CI_W'(N_OUT-1);

  if (N_IN < 1) begin : g_bad_n_in
    $error("dnn_fc_sigmoid_gen: N_IN must be >= 1");
  end
  if (N_OUT < 2) begin : g_bad_n_out
    $error("dnn_fc_sigmoid_gen: N_OUT must be >= 2");
  end
  if (LUT_AW > ADDR_WIDTH) begin : g_bad_lut_aw
    $error("dnn_fc_sigmoid_gen: LUT_AW must be <= ADDR_WIDTH");
  end

  typedef enum logic [3:0] {
    IDLE, LOAD, LOAD_TAIL, MAC, DRAIN, LUT_REQ, LUT_CAP, ARGMAX, DONE
  } state_t;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               cnt;
  logic [CI_W-1:0]                neuron;
  logic [ADDR_WIDTH-1:0]          w_base;
  logic signed [DATA_WIDTH-1:0]   act [N_IN];
  logic signed [ACC_W-1:0]        acc;
  logic                           ld_vld_p1;
  logic [AK_W-1:0]                ld_k_p1;
  logic                           vld_p1;
  logic                           bias_p1;
  logic [AK_W-1:0]                mac_k_p1;
  logic signed [DATA_WIDTH-1:0]   coef_p1;
  logic signed [PROD_W-1:0]       prod_p1;
  logic [LUT_AW-1:0]              lut_idx;
  logic [CI_W-1:0]                scan_idx;
  logic                           run_req;

  // Saturate the shifted accumulator into the LUT's signed range, then bias it to an unsigned index.
  function automatic logic [LUT_AW-1:0] lut_index(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> LUT_SHIFT;
    if (s > SAT_HI)      s = SAT_HI;
    else if (s < SAT_LO) s = SAT_LO;
    return s[LUT_AW-1:0] + IDX_OFS;
  endfunction

  assign run_req  = start && (state == IDLE || state == DONE);
  assign scan_idx = cnt[CI_W-1:0];
  assign lut_idx  = lut_index(acc);
  assign done     = (state == DONE);
  assign busy     = (state != IDLE) && (state != DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = LOAD;
      LOAD:      if (cnt == LOAD_LAST) state_nxt = LOAD_TAIL;
      LOAD_TAIL: state_nxt = MAC;
      MAC:       if (cnt == MAC_LAST) state_nxt = DRAIN;
      DRAIN:     state_nxt = LUT_REQ;
      LUT_REQ:   state_nxt = LUT_CAP;
      LUT_CAP:   state_nxt = (neuron == NEUR_LAST) ? ARGMAX : MAC;
      ARGMAX:    if (cnt == ARG_LAST) state_nxt = DONE;
      DONE:      if (start) state_nxt = LOAD;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    case (state)
      LOAD:    mem_addr = ADDR_WIDTH'(ADDR_BASE_A) + ADDR_WIDTH'(cnt);
      MAC:     mem_addr = w_base + ADDR_WIDTH'(cnt);
      LUT_REQ: mem_addr = ADDR_WIDTH'(ADDR_BASE_LUT) + ADDR_WIDTH'(lut_idx);
      default: mem_addr = '0;
    endcase
  end

  // p0: sequencing and read-request side; the index of each request travels one cycle with its data
  always_ff @(posedge clk) begin
    if (rst || reset) begin
      state     <= IDLE;
      cnt       <= '0;
      neuron    <= '0;
      w_base    <= ADDR_WIDTH'(ADDR_BASE_W);
      ld_vld_p1 <= 1'b0;
      ld_k_p1   <= '0;
      vld_p1    <= 1'b0;
      bias_p1   <= 1'b0;
      mac_k_p1  <= '0;
    end else begin
      state     <= state_nxt;
      ld_vld_p1 <= (state == LOAD);
      ld_k_p1   <= cnt[AK_W-1:0];
      vld_p1    <= (state == MAC);
      bias_p1   <= (cnt == MAC_LAST);
      mac_k_p1  <= cnt[AK_W-1:0];
      if (run_req) begin
        cnt    <= '0;
        neuron <= '0;
        w_base <= ADDR_WIDTH'(ADDR_BASE_W);
      end else begin
        case (state)
          LOAD:    cnt <= (cnt == LOAD_LAST) ? '0 : cnt + CNT_W'(1);
          MAC:     cnt <= (cnt == MAC_LAST) ? '0 : cnt + CNT_W'(1);
          LUT_CAP: begin
            cnt    <= '0;
            neuron <= neuron + CI_W'(1);
            w_base <= w_base + ROW_STRIDE;
          end
          ARGMAX:  cnt <= cnt + CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // p1: read data arrives; the bias term is weighted by the constant activation
  assign coef_p1 = bias_p1 ? ONE_S : act[mac_k_p1];
  assign prod_p1 = PROD_W'(mem_data) * PROD_W'(coef_p1);

  always_ff @(posedge clk) begin
    if (rst || reset) begin
      acc       <= '0;
      class_idx <= '0;
      class_val <= '0;
      for (int i = 0; i < N_IN; i++)  act[i] <= '0;
      for (int i = 0; i < N_OUT; i++) out[i] <= '0;
    end else begin
      if (ld_vld_p1) act[ld_k_p1] <= mem_data;
      if (state == LUT_CAP) begin
        acc         <= '0;
        out[neuron] <= mem_data;
      end else if (vld_p1) begin
        acc <= acc + ACC_W'(prod_p1);
      end
      // strict compare keeps the lowest index on ties
      if (state == ARGMAX && (cnt == '0 || out[scan_idx] > class_val)) begin
        class_idx <= scan_idx;
        class_val <= out[scan_idx];
      end
    end
  end

endmodule
